// File: rtl/pll_lock_supervisor.sv
// PLL power-up sequencer: holds the PLL in reset, waits for a qualified lock,
// then releases the downstream reset; retries on timeout and faults when attempts run out.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic             pll_rst_q;
  logic             sys_rst_n_q;
  logic             ready_q;
  logic             fault_q;
  logic [3:0]       retry_cnt_q;
  logic [7:0]       relock_cnt_q;
  logic [7:0]       relock_cnt_d;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lock_s       = sync_q[1];
  assign cnt_d        = cnt_q + CNT_W'(1);
  assign relock_cnt_d = (relock_cnt_q == 8'hFF) ? relock_cnt_q : relock_cnt_q + 8'd1;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      retry_cnt_q  <= '0;
      relock_cnt_q <= '0;
    end else if (soft_restart) begin
      // Restart wins over every state transition; the relock history is kept.
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          pll_rst_q <= 1'b1;
          if (cnt_q == RST_LAST) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= S_STABILIZE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_cnt_q == RETRY_LIMIT) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q     <= S_RESET_PLL;
              retry_cnt_q <= retry_cnt_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_STABILIZE: begin
          // Any synchronized low restarts qualification with a fresh timeout.
          if (!lock_s) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            retry_cnt_q  <= '0;
            relock_cnt_q <= relock_cnt_d;
            pll_rst_q    <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
          end
        end

        S_FAULT: begin
          fault_q     <= 1'b1;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end

        default: begin
          state_q     <= S_RESET_PLL;
          cnt_q       <= '0;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_cnt_q;
  assign relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters (4/20/8/2);
// outputs are sampled 1 ns after each rising edge, inputs change at the same point.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] relock_cnt;

  int checks   = 0;
  int failures = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES    (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2),
    .CNT_W             (16)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_restart(soft_restart),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .relock_cnt  (relock_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic edges(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"},   32'(pll_rst),    32'd1);
    check({tag, "_sys_rst_n"}, 32'(sys_rst_n),  32'd0);
    check({tag, "_ready"},     32'(ready),      32'd0);
    check({tag, "_fault"},     32'(fault),      32'd0);
    check({tag, "_retry"},     32'(retry_cnt),  32'd0);
    check({tag, "_relock"},    32'(relock_cnt), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    soft_restart = 1'b0;

    // Reset, then release with no lock: pll_rst high for exactly 4 edges.
    edges(2);
    check_reset_values("rst");
    rst_n = 1'b1;
    edges(3);
    check("rel_pll_rst_e3", 32'(pll_rst), 32'd1);
    edges(1);
    check("rel_pll_rst_e4", 32'(pll_rst), 32'd0);

    // Lock in WAIT_LOCK: ready after edge 11 (8 stable + 3).
    pll_locked = 1'b1;
    edges(10);
    check("acq_ready_e10", 32'(ready), 32'd0);
    edges(1);
    check("acq_ready_e11",  32'(ready),     32'd1);
    check("acq_sysrst_e11", 32'(sys_rst_n), 32'd1);
    check("acq_retry",      32'(retry_cnt), 32'd0);

    // Lock loss in RUN: outputs drop after the 3rd edge.
    pll_locked = 1'b0;
    edges(2);
    check("loss_sysrst_e2", 32'(sys_rst_n), 32'd1);
    edges(1);
    check("loss_sysrst_e3",  32'(sys_rst_n),  32'd0);
    check("loss_ready_e3",   32'(ready),      32'd0);
    check("loss_pll_rst_e3", 32'(pll_rst),    32'd1);
    check("loss_relock_1",   32'(relock_cnt), 32'd1);
    edges(4);
    check("loss_back_wait", 32'(pll_rst), 32'd0);

    // Glitch in STABILIZE at cnt=5: low for 3 edges, then qualification restarts.
    pll_locked = 1'b1;
    edges(8);
    check("glitch_ready_pre", 32'(ready), 32'd0);
    pll_locked = 1'b0;
    edges(3);
    check("glitch_ready_low", 32'(ready), 32'd0);
    pll_locked = 1'b1;
    edges(10);
    check("glitch_ready_e10", 32'(ready), 32'd0);
    edges(1);
    check("glitch_ready_e11", 32'(ready),     32'd1);
    check("glitch_sysrst",    32'(sys_rst_n), 32'd1);
    check("glitch_retry",     32'(retry_cnt), 32'd0);

    // Second loss (relock=2), then rst_n at STABILIZE cnt=6.
    pll_locked = 1'b0;
    edges(3);
    check("loss2_relock_2", 32'(relock_cnt), 32'd2);
    edges(4);
    pll_locked = 1'b1;
    edges(9);
    check("stab6_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    edges(1);
    check_reset_values("midrst");
    pll_locked = 1'b0;
    rst_n      = 1'b1;

    // No lock ever: three 20-cycle timeouts, then FAULT.
    edges(4);
    check("to0_pll_rst_low", 32'(pll_rst), 32'd0);
    edges(19);
    check("to1_pre_pll_rst", 32'(pll_rst), 32'd0);
    edges(1);
    check("to1_pll_rst", 32'(pll_rst),   32'd1);
    check("to1_retry",   32'(retry_cnt), 32'd1);
    edges(4);
    check("to1_wait", 32'(pll_rst), 32'd0);
    edges(20);
    check("to2_pll_rst", 32'(pll_rst),   32'd1);
    check("to2_retry",   32'(retry_cnt), 32'd2);
    edges(4);
    edges(19);
    check("to3_pre_fault", 32'(fault), 32'd0);
    edges(1);
    check("to3_fault",   32'(fault),     32'd1);
    check("to3_pll_rst", 32'(pll_rst),   32'd1);
    check("to3_retry",   32'(retry_cnt), 32'd2);
    edges(5);
    check("fault_held", 32'(fault), 32'd1);

    // soft_restart clears the fault and runs a fresh 4-cycle pll_rst.
    soft_restart = 1'b1;
    edges(1);
    soft_restart = 1'b0;
    check("soft_fault",   32'(fault),     32'd0);
    check("soft_retry",   32'(retry_cnt), 32'd0);
    check("soft_pll_rst", 32'(pll_rst),   32'd1);
    edges(3);
    check("soft_pll_rst_e3", 32'(pll_rst), 32'd1);
    edges(1);
    check("soft_pll_rst_e4", 32'(pll_rst), 32'd0);

    // 256 lock losses: relock_cnt saturates at 255.
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b1;
      edges(11);
      check("sat_ready", 32'(ready), 32'd1);
      pll_locked = 1'b0;
      edges(3);
      if (i == 0)   check("sat_relock_1",   32'(relock_cnt), 32'd1);
      if (i == 254) check("sat_relock_255", 32'(relock_cnt), 32'd255);
      edges(4);
    end
    check("sat_relock_final", 32'(relock_cnt), 32'd255);

    // soft_restart from RUN: immediate drop, relock_cnt preserved.
    pll_locked = 1'b1;
    edges(11);
    check("run_ready", 32'(ready), 32'd1);
    soft_restart = 1'b1;
    edges(1);
    soft_restart = 1'b0;
    check("srun_ready",   32'(ready),      32'd0);
    check("srun_sysrst",  32'(sys_rst_n),  32'd0);
    check("srun_pll_rst", 32'(pll_rst),    32'd1);
    check("srun_relock",  32'(relock_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the 50 MHz→100 MHz system PLL: holds it in reset after power-up and retries lock within a timeout. It qualifies `locked` over a stability window, then releases the downstream system reset. It sits between the board reset/refclk and the PLL wrapper. It re-sequences on loss of lock and latches a fault after repeated lock failures.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1)
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before retry (≥1)
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1)
- `MAX_RETRIES`, 3: retries after the first attempt before FAULT (0..15)
- `CNT_W`, 16: shared counter width; must hold max(param)−1

- `refclk` in 1: sole clock, PLL reference clock
- `rst_n` in 1: synchronous, active-low reset
- `pll_locked` in 1: PLL `locked`, asynchronous to refclk
- `soft_restart` in 1: single-cycle request to restart sequencing
- `pll_rst` out 1: PLL reset, active-high
- `sys_rst_n` out 1: downstream reset, active-low
- `ready` out 1: PLL locked and qualified
- `fault` out 1: lock attempts exhausted
- `retry_cnt` out 4: timeouts in the current sequence
- `relock_cnt` out 8: lock losses seen in RUN, saturating at 255

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset 0); output `lock_s` drives the FSM.
- All outputs are registered and change on the edge where the state changes.
- Reset (`rst_n`=0 at an edge): state RESET_PLL, cnt=0, sync flops=0, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, `relock_cnt`=0. Reset overrides every other input.
- RESET_PLL: `pll_rst`=1 and cnt increments. At cnt==PLL_RST_CYCLES−1: go to WAIT_LOCK, cnt=0, `pll_rst`=0.
- WAIT_LOCK: cnt increments.
  - If `lock_s`=1: go to STABILIZE, cnt=0.
  - Else, at cnt==LOCK_TIMEOUT−1:
    - If `retry_cnt`==MAX_RETRIES: go to FAULT.
    - Otherwise: `retry_cnt`++ and go to RESET_PLL, cnt=0.
- STABILIZE: cnt increments.
  - If `lock_s`=0: go to WAIT_LOCK, cnt=0. `retry_cnt` is unchanged and the timeout restarts.
  - At cnt==LOCK_STABLE_CYCLES−1 with `lock_s`=1: go to RUN, `sys_rst_n`=1, `ready`=1.
- RUN: if `lock_s`=0:
  - go to RESET_PLL with cnt=0 and `retry_cnt`=0;
  - `relock_cnt`++ (saturating at 255);
  - `sys_rst_n`=0, `ready`=0, `pll_rst`=1.
- FAULT: `fault`=1, `pll_rst`=1, `sys_rst_n`=0, `ready`=0. Held until `rst_n` or `soft_restart`.
- `soft_restart`=1 in any state: go to RESET_PLL, cnt=0, `retry_cnt`=0, `fault`=0, `sys_rst_n`=0, `ready`=0, `pll_rst`=1.
  - `relock_cnt` is preserved.
  - This has priority over all other transitions in the same cycle.
- Total attempts before FAULT = MAX_RETRIES+1.

## Timing
- After reset release, `pll_rst` stays high for exactly PLL_RST_CYCLES edges.
- Lock acquire: number the first edge sampling `pll_locked`=1 in WAIT_LOCK as edge 1. If lock is held, `sys_rst_n`/`ready` go high after edge LOCK_STABLE_CYCLES+3.
- Lock loss in RUN: with edge 1 as the first edge sampling `pll_locked`=0, `sys_rst_n`/`ready` fall and `pll_rst` rises after edge 3.
- Glitches on `pll_locked` shorter than one refclk period may be missed. Any synchronized low in STABILIZE restarts qualification.
- Timeout: `pll_rst` reasserts LOCK_TIMEOUT edges after it deasserted when no lock is seen.
- `soft_restart` takes effect on the edge that samples it.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Reset then release, `pll_locked`=0:
  - reset values hold during reset;
  - `pll_rst`=1 for 4 edges, then 0.
- `pll_locked` rises in WAIT_LOCK and stays high: `sys_rst_n`=`ready`=1 after edge 11; `retry_cnt`=0.
- `pll_locked` drops for 3 cycles at STABILIZE cnt=5, then returns:
  - FSM returns to WAIT_LOCK;
  - `ready` rises 11 edges after re-rise;
  - `retry_cnt`=0.
- `pll_locked` never rises:
  - three 20-cycle timeouts, `retry_cnt` 0→1→2, then `fault`=1 and `pll_rst`=1;
  - `soft_restart` pulse gives `fault`=0, `retry_cnt`=0 and a 4-cycle `pll_rst` sequence.
- Lock loss in RUN:
  - `sys_rst_n` falls after the 3rd edge, `relock_cnt`=1;
  - after 256 losses `relock_cnt`=255.
- `rst_n`=0 at STABILIZE cnt=6 with `relock_cnt`=2: all outputs return to reset values on the next edge, `relock_cnt`=0.
